// File: rtl/fifo_rr_drain_pkg.sv
// Shared definitions for the FIFO round-robin drain stage.
//   - Default word width, FIFO depth and FIFO count used by the
//     fifo_counter / fifo_mem / fifo_rr_drain family.
//   - sel_w(): width of a source index for a given FIFO count (min 1 bit).
//   - drain_state_e: state of the single-entry output register.
package fifo_rr_drain_pkg;

  localparam int BITS_DEF    = 4;
  localparam int DEPTH_DEF   = 8;
  localparam int N_FIFOS_DEF = 4;

  // A single FIFO still needs a 1-bit index port.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // EMPTY/LOADED mirrors valid_out exactly.
  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } drain_state_e;

endpackage

// File: rtl/fifo_rr_drain_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req        in  N      request vector
//   last       in  SEL_W  index granted most recently
//   gnt_onehot out N      one-hot grant, zero when no request
//   gnt_idx    out SEL_W  index of the grant, zero when no request
//   any        out 1      at least one request is set
// Search starts one past `last` and wraps modulo N, so the most recent
// winner has the lowest priority.
module rr_arbiter
  import fifo_rr_drain_pkg::*;
#(
  parameter int N     = N_FIFOS_DEF,
  parameter int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic [N-1:0]     gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  always_comb begin
    // NOTE: every output gets a default before the search loop so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int off = 1; off <= N; off++) begin
      automatic int idx = (int'(last) + off) % N;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_drain.sv
// fifo_rr_drain: drains N_FIFOS upstream FIFOs into one valid/ready stream.
//   clk       in  1             rising-edge clock
//   rst       in  1             synchronous active-high reset
//   pndng_in  in  N_FIFOS       per-FIFO data-available flag
//   data_in   in  N_FIFOS*BITS  per-FIFO head word, FIFO i at [i*BITS +: BITS]
//   pop_out   out N_FIFOS       one-hot-or-zero pop strobe (combinational)
//   data_out  out BITS          registered word
//   src_out   out SEL_W         FIFO that supplied data_out
//   valid_out out 1             data_out/src_out hold a word
//   ready_in  in  1             consumer takes the word when valid_out & ready_in
// A pop is issued whenever the output slot is free or being emptied this
// cycle, which gives one word per cycle under a constantly ready consumer.
module fifo_rr_drain
  import fifo_rr_drain_pkg::*;
#(
  parameter int BITS    = BITS_DEF,
  parameter int N_FIFOS = N_FIFOS_DEF,
  parameter int SEL_W   = sel_w(N_FIFOS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_FIFOS-1:0]      pndng_in,
  input  logic [N_FIFOS*BITS-1:0] data_in,
  output logic [N_FIFOS-1:0]      pop_out,
  output logic [BITS-1:0]         data_out,
  output logic [SEL_W-1:0]        src_out,
  output logic                    valid_out,
  input  logic                    ready_in
);

  drain_state_e     state_q, state_d;
  logic [BITS-1:0]  data_q, data_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic [N_FIFOS-1:0] gnt_onehot;
  logic [SEL_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               can_load;
  logic               pop;

  rr_arbiter #(
    .N     (N_FIFOS),
    .SEL_W (SEL_W)
  ) u_arb (
    .req        (pndng_in),
    .last       (last_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // Slot is free if empty, or if the held word leaves on this edge.
  assign can_load = (state_q == ST_EMPTY) || ready_in;
  // Pops are suppressed during reset so no upstream entry is lost.
  assign pop      = !rst && can_load && gnt_any;
  assign pop_out  = pop ? gnt_onehot : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    if (pop) begin
      state_d = ST_LOADED;
      data_d  = data_in[int'(gnt_idx)*BITS +: BITS];
      src_d   = gnt_idx;
      last_d  = gnt_idx;
    end else if ((state_q == ST_LOADED) && ready_in) begin
      state_d = ST_EMPTY;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      last_q  <= SEL_W'(N_FIFOS - 1);  // first grant after reset is FIFO 0
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  assign valid_out = (state_q == ST_LOADED);
  assign data_out  = data_q;
  assign src_out   = src_q;

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Testbench for fifo_rr_drain (BITS=4, N_FIFOS=4).
// Directed vector table covering reset, rotation, backpressure, sparse
// requests and priority wrap, followed by a randomized phase in which the
// upstream FIFOs and the output stream are modelled with queues.
module tb_fifo_rr_drain;

  localparam int BITS = 4;
  localparam int N    = 4;
  localparam int SW   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      pndng_in = '0;
  logic [N*BITS-1:0] data_in = '0;
  logic [N-1:0]      pop_out;
  logic [BITS-1:0]   data_out;
  logic [SW-1:0]     src_out;
  logic              valid_out;
  logic              ready_in = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  fifo_rr_drain #(.BITS(BITS), .N_FIFOS(N), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .pndng_in  (pndng_in),
    .data_in   (data_in),
    .pop_out   (pop_out),
    .data_out  (data_out),
    .src_out   (src_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Safety properties checked every cycle outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("pop_onehot0", 16'($onehot0(pop_out)), 16'd1);
      check("pop_not_pending", 16'(pop_out & ~pndng_in), 16'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  pndng;
    logic [15:0]   data;
    logic          ready;
    logic [N-1:0]  exp_pop;
    logic          exp_valid;
    logic [3:0]    exp_data;
    logic [SW-1:0] exp_src;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] p, input logic [15:0] d,
                     input logic rdy, input logic [3:0] ep, input logic ev,
                     input logic [3:0] ed, input logic [1:0] es);
    vec_t v;
    v.rst = r; v.pndng = p; v.data = d; v.ready = rdy;
    v.exp_pop = ep; v.exp_valid = ev; v.exp_data = ed; v.exp_src = es;
    vecs.push_back(v);
  endtask

  // Bench-side model for the random phase.
  logic [BITS-1:0] fq[N][$];
  logic [BITS-1:0] sb_data[$];
  int              sb_src[$];
  bit              m_valid;
  int              m_last;

  initial begin
    // ---- directed table ----
    //   rst p        data      rdy pop      v  d     s
    add(1, 4'b1111, 16'h4321, 1, 4'b0000, 0, 4'h0, 0);  // reset
    add(0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 4'h1, 0);  // rotation
    add(0, 4'b1111, 16'h4321, 1, 4'b0010, 1, 4'h2, 1);
    add(0, 4'b1111, 16'h4321, 1, 4'b0100, 1, 4'h3, 2);
    add(0, 4'b1111, 16'h4321, 1, 4'b1000, 1, 4'h4, 3);
    add(0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 4'h1, 0);
    add(0, 4'b0100, 16'h0500, 1, 4'b0100, 1, 4'h5, 2);  // load 5 from FIFO 2
    for (int i = 0; i < 5; i++)                          // backpressure
      add(0, 4'b1000, 16'h9500, 0, 4'b0000, 1, 4'h5, 2);
    add(0, 4'b1000, 16'h9500, 1, 4'b1000, 1, 4'h9, 3);  // release, pop same cycle
    add(0, 4'b0010, 16'h0070, 1, 4'b0010, 1, 4'h7, 1);  // sparse FIFO 1
    add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h7, 1);
    add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h7, 1);
    add(0, 4'b1000, 16'hB000, 1, 4'b1000, 1, 4'hB, 3);  // last_grant = 3
    add(0, 4'b1001, 16'hC00D, 1, 4'b0001, 1, 4'hD, 0);  // wrap to 0
    add(0, 4'b1001, 16'hC00D, 1, 4'b1000, 1, 4'hC, 3);
    add(0, 4'b1001, 16'hC00D, 1, 4'b0001, 1, 4'hD, 0);
    add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'hD, 0);
    add(0, 4'b0000, 16'h0000, 0, 4'b0000, 0, 4'hD, 0);  // ready ignored when empty
    add(0, 4'b0010, 16'h00A0, 1, 4'b0010, 1, 4'hA, 1);  // hold A
    add(0, 4'b1111, 16'h4321, 0, 4'b0000, 1, 4'hA, 1);
    add(1, 4'b1111, 16'h4321, 1, 4'b0000, 0, 4'h0, 0);  // reset mid-traffic
    add(0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 4'h1, 0);  // first grant FIFO 0

    tick();
    foreach (vecs[k]) begin
      rst      = vecs[k].rst;
      pndng_in = vecs[k].pndng;
      data_in  = vecs[k].data;
      ready_in = vecs[k].ready;
      @(negedge clk);
      check($sformatf("v%0d_pop", k), 16'(pop_out), 16'(vecs[k].exp_pop));
      tick();
      check($sformatf("v%0d_valid", k), 16'(valid_out), 16'(vecs[k].exp_valid));
      check($sformatf("v%0d_data", k), 16'(data_out), 16'(vecs[k].exp_data));
      check($sformatf("v%0d_src", k), 16'(src_out), 16'(vecs[k].exp_src));
    end

    // ---- randomized phase ----
    rst = 1'b1; pndng_in = '0; ready_in = 1'b0;
    tick();
    rst = 1'b0;
    m_valid = 1'b0;
    m_last  = N - 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int          g;
      logic [N-1:0] exp_pop;
      // upstream producers
      if ($urandom_range(0, 2) != 0) begin
        int f = $urandom_range(0, N - 1);
        if (fq[f].size() < 8) fq[f].push_back(BITS'($urandom));
      end
      for (int i = 0; i < N; i++) begin
        pndng_in[i] = (fq[i].size() > 0);
        data_in[i*BITS +: BITS] = (fq[i].size() > 0) ? fq[i][0] : BITS'($urandom);
      end
      ready_in = ($urandom_range(0, 3) != 0);
      // expected grant: first pending FIFO after the last winner
      g = -1;
      if (!m_valid || ready_in)
        for (int k = 1; k <= N && g < 0; k++)
          if (fq[(m_last + k) % N].size() > 0) g = (m_last + k) % N;
      exp_pop = (g >= 0) ? N'(1 << g) : '0;

      @(negedge clk);
      check("rnd_pop", 16'(pop_out), 16'(exp_pop));
      check("rnd_valid", 16'(valid_out), 16'(m_valid));
      if (m_valid && ready_in) begin
        if (sb_data.size() == 0) begin
          check("rnd_sb_underflow", 16'd1, 16'd0);
        end else begin
          check("rnd_data", 16'(data_out), 16'(sb_data.pop_front()));
          check("rnd_src", 16'(src_out), 16'(sb_src.pop_front()));
        end
      end
      tick();
      if (g >= 0) begin
        sb_data.push_back(fq[g].pop_front());
        sb_src.push_back(g);
        m_last  = g;
        m_valid = 1'b1;
      end else if (m_valid && ready_in) begin
        m_valid = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
